// File: rtl/normal_reader_if.sv
// Read-port bundle between the segment memory and its scan engine.
// Address and segment select flow to the memory; VALUE returns two cycles later.
interface normal_bus_if;
    logic [7:0]  ADDR;
    logic        SEGMENT;
    logic [15:0] VALUE;

    modport out_port (output ADDR, output SEGMENT, input VALUE);
    modport in_port  (input ADDR, input SEGMENT, output VALUE);
endinterface

// File: rtl/normal_reader.sv
// Normal-mode scan engine: sweeps one latched segment of the memory and
// emits a registered per-transducer intensity/phase/index stream.
module normal_reader #(
    parameter int DEPTH        = 249,
    parameter int READ_LATENCY = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                START,
    input  logic                SEGMENT_IN,
    normal_bus_if.out_port      NORMAL_BUS,
    output logic [7:0]          INTENSITY,
    output logic [7:0]          PHASE,
    output logic [7:0]          IDX,
    output logic                DOUT_VALID,
    output logic                BUSY,
    output logic                DONE
);

    localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [7:0]              addr_r, addr_s;
    logic                    segment_r, segment_s;
    logic                    pending_r, pending_s;
    logic                    issue_s;
    logic                    last_s;
    logic [READ_LATENCY-1:0] vld_sr_r;
    logic [7:0]              idx_sr_r [READ_LATENCY];

    assign NORMAL_BUS.ADDR    = addr_r;
    assign NORMAL_BUS.SEGMENT = segment_r;

    // Entry leaving the shift register is the scan's last one.
    assign last_s = vld_sr_r[READ_LATENCY-1] && (idx_sr_r[READ_LATENCY-1] == LAST_ADDR);

    // Next-state, address sequencing and one-deep restart request.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        segment_s = segment_r;
        pending_s = pending_r;
        issue_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_s   = ST_RUN;
                    addr_s    = 8'd0;
                    segment_s = SEGMENT_IN;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                issue_s = 1'b1;
                if (START) begin
                    pending_s = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
                if (addr_r == LAST_ADDR) begin
                    state_s = ST_DRAIN;
                end else begin
                    addr_s  = addr_r + 8'd1;
                end
            end
            ST_DRAIN: begin
                // DONE marks the final entry; a queued or fresh request relaunches here.
                if (DONE) begin
                    if (pending_r || START) begin
                        state_s   = ST_RUN;
                        addr_s    = 8'd0;
                        segment_s = SEGMENT_IN;
                        pending_s = 1'b0;
                    end else begin
                        state_s   = ST_IDLE;
                    end
                end else if (START) begin
                    pending_s = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            addr_r    <= 8'd0;
            segment_r <= 1'b0;
            pending_r <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            segment_r <= segment_s;
            pending_r <= pending_s;
            BUSY      <= (state_s != ST_IDLE);
        end
    end

    // Latency-matched valid/index pipeline and output register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            vld_sr_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                idx_sr_r[i] <= 8'd0;
            end
            INTENSITY  <= 8'd0;
            PHASE      <= 8'd0;
            IDX        <= 8'd0;
            DOUT_VALID <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            vld_sr_r[0] <= issue_s;
            idx_sr_r[0] <= addr_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr_r[i] <= vld_sr_r[i-1];
                idx_sr_r[i] <= idx_sr_r[i-1];
            end
            DOUT_VALID <= vld_sr_r[READ_LATENCY-1];
            DONE       <= last_s;
            if (vld_sr_r[READ_LATENCY-1]) begin
                INTENSITY <= NORMAL_BUS.VALUE[15:8];
                PHASE     <= NORMAL_BUS.VALUE[7:0];
                IDX       <= idx_sr_r[READ_LATENCY-1];
            end else begin
                INTENSITY <= INTENSITY;
                PHASE     <= PHASE;
                IDX       <= IDX;
            end
        end
    end

endmodule

// File: tb/tb_normal_reader.sv
// Randomized bench for normal_reader: a 2-cycle BRAM model feeds the DUT and a
// scan-level reference model predicts every output cycle by cycle.
module tb_normal_reader;

    localparam int DEPTH    = 249;
    localparam int RL       = 2;
    localparam int FIRST_OFS = RL + 2;           // START cycle -> first valid entry
    localparam int DONE_OFS  = DEPTH + RL + 1;   // START cycle -> DONE cycle

    logic       clk = 1'b0;
    logic       RESET_N, START, SEGMENT_IN;
    logic [7:0] intensity, phase, idx;
    logic       dout_valid, busy, done;

    normal_bus_if bus ();

    normal_reader #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .CLK        (clk),
        .RESET_N    (RESET_N),
        .START      (START),
        .SEGMENT_IN (SEGMENT_IN),
        .NORMAL_BUS (bus),
        .INTENSITY  (intensity),
        .PHASE      (phase),
        .IDX        (idx),
        .DOUT_VALID (dout_valid),
        .BUSY       (busy),
        .DONE       (done)
    );

    always #5 clk = ~clk;

    // Segment memory with two-cycle read latency.
    logic [15:0] mem [2][256];
    logic [15:0] rd_s1;
    always @(posedge clk) begin
        rd_s1     <= mem[bus.SEGMENT][bus.ADDR];
        bus.VALUE <= rd_s1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: scan launches as (cycle, segment) plus a pending flag.
    bit   m_active  = 1'b0;
    bit   m_pending = 1'b0;
    bit   have_scan [2];
    int   scan_l    [2];
    logic scan_seg  [2];
    logic [7:0] h_int = 8'd0, h_ph = 8'd0, h_idx = 8'd0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        logic       ev, ed, eb;
        logic [7:0] ea;
        int         k;
        ev = 1'b0; ed = 1'b0; eb = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (have_scan[s]) begin
                k = cyc - scan_l[s] - FIRST_OFS;
                if (k >= 0 && k < DEPTH) begin
                    ev    = 1'b1;
                    ed    = (k == DEPTH - 1);
                    h_idx = 8'(k);
                    h_int = mem[scan_seg[s]][k][15:8];
                    h_ph  = mem[scan_seg[s]][k][7:0];
                end
                if (cyc >= scan_l[s] + 1 && cyc <= scan_l[s] + DONE_OFS) eb = 1'b1;
            end
        end
        if (!have_scan[1]) ea = 8'd0;
        else if (cyc - scan_l[1] - 1 < DEPTH) ea = 8'(cyc - scan_l[1] - 1);
        else ea = 8'(DEPTH - 1);
        check_eq("dout_valid", 16'(dout_valid), 16'(ev));
        check_eq("done",       16'(done),       16'(ed));
        check_eq("busy",       16'(busy),       16'(eb));
        check_eq("addr",       16'(bus.ADDR),   16'(ea));
        check_eq("idx",        16'(idx),        16'(h_idx));
        check_eq("intensity",  16'(intensity),  16'(h_int));
        check_eq("phase",      16'(phase),      16'(h_ph));
    endtask

    // Drive one cycle, advance the model, then check the post-edge outputs.
    task automatic step(input logic st, input logic sg, input logic rn);
        bit launch;
        START = st; SEGMENT_IN = sg; RESET_N = rn;
        launch = 1'b0;
        if (!rn) begin
            m_active = 1'b0; m_pending = 1'b0;
            have_scan[0] = 1'b0; have_scan[1] = 1'b0;
            h_int = 8'd0; h_ph = 8'd0; h_idx = 8'd0;
        end else if (!m_active) begin
            launch = st;
        end else if (cyc == scan_l[1] + DONE_OFS) begin
            launch = st || m_pending;
            if (!launch) m_active = 1'b0;
        end else if (st) begin
            m_pending = 1'b1;
        end
        if (launch) begin
            have_scan[0] = have_scan[1]; scan_l[0] = scan_l[1]; scan_seg[0] = scan_seg[1];
            have_scan[1] = 1'b1; scan_l[1] = cyc; scan_seg[1] = sg;
            m_active = 1'b1; m_pending = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    // Run n cycles with STARTs at relative cycles s0/s1/s2 and reset at rst_at.
    task automatic scenario(input int n, input int s0, input int s1, input int s2,
                            input int rst_at, input logic seg);
        for (int i = 0; i < n; i++) begin
            logic st, sg;
            st = (i == s0) || (i == s1) || (i == s2);
            sg = (i == s0) ? seg : 1'($urandom_range(0, 1));
            step(st, sg, (i == rst_at) ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 256; a++) mem[s][a] = 16'($urandom);
        end
        have_scan[0] = 1'b0; have_scan[1] = 1'b0;
        scan_l[0] = 0; scan_l[1] = 0; scan_seg[0] = 1'b0; scan_seg[1] = 1'b0;
        START = 1'b0; SEGMENT_IN = 1'b0; RESET_N = 1'b0;

        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        scenario(100, -1, -1, -1, -1, 1'b0);      // idle: ADDR stays 0
        scenario(260, 0, -1, -1, -1, 1'b0);       // segment 0 scan
        scenario(260, 0, -1, -1, -1, 1'b1);       // segment 1, SEGMENT_IN noise mid-scan
        scenario(520, 0, 50, 60, -1, 1'b0);       // pending restart, third request dropped
        scenario(520, 0, DONE_OFS, -1, -1, 1'b1); // START in the DONE cycle
        scenario(130, 0, -1, -1, 120, 1'b0);      // reset mid-scan
        scenario(260, 0, -1, -1, -1, 1'b1);       // full scan after abort
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 1'b1);
        end
        scenario(260, -1, -1, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
